// File: rtl/control_path_pkg.sv
// -----------------------------------------------------------------------------
// control_path_pkg
// Shared types for the p18240 processor: the FSM state names (opcode_t),
// the datapath control-field enums, the control-point struct and the
// instruction opcodes decoded from IR[15:9]. The datapath, the top level and
// the control path all import this package.
// The ADD32 states are always declared here. Whether the FSM ever reaches
// them depends on the ADD32_EN macro in control_path.sv.
// -----------------------------------------------------------------------------
package control_path_pkg;

   typedef enum logic [5:0] {
      FETCH, FETCH1, FETCH2, DECODE,
      ADD, SUB, AND, OR, XOR, NOT, MOV,
      LDI, LDI1, LDI2,
      LD, LD1, LD2, LD3, LD4,
      ST, ST1, ST2, ST3, ST4,
      BRA, BRA1, BRA2, BRA3,
      BRZ, BRZ1, BRZ2, BRZ3,
      BRN, BRN1, BRN2, BRN3,
      BRC, BRC1, BRC2, BRC3,
      BRV, BRV1, BRV2, BRV3,
      ADD32, ADD321,
      STOP
   } opcode_t;

   typedef enum logic [3:0] {
      F_A, F_A_PLUS_1, F_A_PLUS_B, F_A_MINUS_B,
      F_A_AND_B, F_A_OR_B, F_A_XOR_B, F_A_NOT, F_B
   } alu_op_t;

   typedef enum logic [1:0] {MUX_REG, MUX_PC, MUX_MDR} srcMux_t;

   typedef enum logic [2:0] {
      DEST_NONE, DEST_REG, DEST_MAR, DEST_PC, DEST_IR, DEST_MDR
   } dest_t;

   // Load, read and write strobes are active low.
   typedef enum logic {LOAD_CC = 1'b0, NO_LOAD = 1'b1} loadCC_t;
   typedef enum logic {MEM_RD  = 1'b0, NO_RD   = 1'b1} memRd_t;
   typedef enum logic {MEM_WR  = 1'b0, NO_WR   = 1'b1} memWr_t;

   typedef struct packed {
      alu_op_t alu_op;
      srcMux_t srcA;
      srcMux_t srcB;
      dest_t   dest;
      loadCC_t lcc_L;
      memRd_t  re_L;
      memWr_t  we_L;
   } controlPts;

   // Instruction opcodes as they appear in IR[15:9].
   localparam logic [6:0] OP_ADD   = 7'h00;
   localparam logic [6:0] OP_SUB   = 7'h01;
   localparam logic [6:0] OP_AND   = 7'h02;
   localparam logic [6:0] OP_OR    = 7'h03;
   localparam logic [6:0] OP_XOR   = 7'h04;
   localparam logic [6:0] OP_NOT   = 7'h05;
   localparam logic [6:0] OP_MOV   = 7'h06;
   localparam logic [6:0] OP_LDI   = 7'h08;
   localparam logic [6:0] OP_LD    = 7'h09;
   localparam logic [6:0] OP_ST    = 7'h0A;
   localparam logic [6:0] OP_BRA   = 7'h10;
   localparam logic [6:0] OP_BRZ   = 7'h11;
   localparam logic [6:0] OP_BRN   = 7'h12;
   localparam logic [6:0] OP_BRC   = 7'h13;
   localparam logic [6:0] OP_BRV   = 7'h14;
   localparam logic [6:0] OP_ADD32 = 7'h20;
   localparam logic [6:0] OP_STOP  = 7'h7F;

endpackage

// File: rtl/control_path_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Combinational branch-condition evaluator. It maps the current branch state
// and the condition codes to a taken bit. Only the BRx1 states produce a
// meaningful result, because the FSM resolves a branch in BRx1.
// Ports:
//   state_i  in  opcode_t  current FSM state
//   cc_i     in  4         condition codes {Z,C,N,V}
//   taken_o  out 1         branch is taken
// -----------------------------------------------------------------------------
module cond_eval
   import control_path_pkg::*;
(
   input  opcode_t    state_i,
   input  logic [3:0] cc_i,
   output logic       taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (state_i)
         BRA1:    taken_o = 1'b1;
         BRZ1:    taken_o = cc_i[3];
         BRC1:    taken_o = cc_i[2];
         BRN1:    taken_o = cc_i[1];
         BRV1:    taken_o = cc_i[0];
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_path.sv
// -----------------------------------------------------------------------------
// control_path
// Multi-cycle Moore FSM that sequences the p18240 16-bit processor. Every
// instruction runs FETCH, FETCH1, FETCH2 and DECODE, then its own execute
// states, and then returns to FETCH. The outputs depend only on currState.
// Optional feature: define ADD32_EN to decode opcode 7'h20 into the two-state
// ADD32/ADD321 sequence. When ADD32_EN is undefined, 7'h20 decodes to STOP and
// ADD32sel stays 0.
// Ports:
//   clock      in   1         rising-edge clock
//   reset_L    in   1         asynchronous active-low reset (forces FETCH)
//   IRIn       in   16        instruction register, opcode = IRIn[15:9]
//   CCin       in   4         condition codes {Z,C,N,V}
//   out        out  controlPts datapath/memory control points
//   ADD32sel   out  1         high in the ADD32 execute states
//   currState  out  opcode_t  registered state (debug/observe)
//   nextState  out  opcode_t  combinational next state
// -----------------------------------------------------------------------------
module control_path
   import control_path_pkg::*;
(
   input  logic        clock,
   input  logic        reset_L,
   input  logic [15:0] IRIn,
   input  logic [3:0]  CCin,
   output controlPts   out,
   output logic        ADD32sel,
   output opcode_t     currState,
   output opcode_t     nextState
);

   opcode_t    state_q, state_d;
   logic       br_taken;
   logic [6:0] opcode;
   logic       unused_ir_low;

   assign opcode        = IRIn[15:9];
   // The operand fields belong to the datapath.
   assign unused_ir_low = ^IRIn[8:0];

   cond_eval u_cond_eval (
      .state_i (state_q),
      .cc_i    (CCin),
      .taken_o (br_taken)
   );

   // State register. Reset forces FETCH asynchronously, which aborts any
   // instruction in progress.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) state_q <= FETCH;
      else          state_q <= state_d;
   end

   // Next-state logic. IRIn is looked at only in DECODE and CCin only in BRx1.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:  state_d = FETCH1;
         FETCH1: state_d = FETCH2;
         FETCH2: state_d = DECODE;
         DECODE: begin
            case (opcode)
               OP_ADD:   state_d = ADD;
               OP_SUB:   state_d = SUB;
               OP_AND:   state_d = AND;
               OP_OR:    state_d = OR;
               OP_XOR:   state_d = XOR;
               OP_NOT:   state_d = NOT;
               OP_MOV:   state_d = MOV;
               OP_LDI:   state_d = LDI;
               OP_LD:    state_d = LD;
               OP_ST:    state_d = ST;
               OP_BRA:   state_d = BRA;
               OP_BRZ:   state_d = BRZ;
               OP_BRN:   state_d = BRN;
               OP_BRC:   state_d = BRC;
               OP_BRV:   state_d = BRV;
`ifdef ADD32_EN
               OP_ADD32: state_d = ADD32;
`endif
               // STOP, and every opcode that is not listed, halts the machine.
               default:  state_d = STOP;
            endcase
         end
         ADD, SUB, AND, OR, XOR, NOT, MOV: state_d = FETCH;
         LDI:    state_d = LDI1;
         LDI1:   state_d = LDI2;
         LDI2:   state_d = FETCH;
         LD:     state_d = LD1;
         LD1:    state_d = LD2;
         LD2:    state_d = LD3;
         LD3:    state_d = LD4;
         LD4:    state_d = FETCH;
         ST:     state_d = ST1;
         ST1:    state_d = ST2;
         ST2:    state_d = ST3;
         ST3:    state_d = ST4;
         ST4:    state_d = FETCH;
         BRA:    state_d = BRA1;
         BRZ:    state_d = BRZ1;
         BRN:    state_d = BRN1;
         BRC:    state_d = BRC1;
         BRV:    state_d = BRV1;
         BRA1:   state_d = br_taken ? BRA2 : BRA3;
         BRZ1:   state_d = br_taken ? BRZ2 : BRZ3;
         BRN1:   state_d = br_taken ? BRN2 : BRN3;
         BRC1:   state_d = br_taken ? BRC2 : BRC3;
         BRV1:   state_d = br_taken ? BRV2 : BRV3;
         BRA2, BRA3, BRZ2, BRZ3, BRN2, BRN3,
         BRC2, BRC3, BRV2, BRV3:          state_d = FETCH;
`ifdef ADD32_EN
         ADD32:  state_d = ADD321;
         ADD321: state_d = FETCH;
`endif
         STOP:   state_d = STOP;
         default: state_d = STOP;
      endcase
   end

   // Moore outputs. Defaults first, and each state overrides only the
   // fields it uses.
   always_comb begin
      out.alu_op = F_A;
      out.srcA   = MUX_REG;
      out.srcB   = MUX_REG;
      out.dest   = DEST_NONE;
      out.lcc_L  = NO_LOAD;
      out.re_L   = NO_RD;
      out.we_L   = NO_WR;
      ADD32sel   = 1'b0;
      case (state_q)
         // MAR <- PC
         FETCH, LDI, LD, ST, BRA, BRZ, BRN, BRC, BRV: begin
            out.srcA = MUX_PC;
            out.dest = DEST_MAR;
         end
         FETCH1: begin
            out.re_L = MEM_RD;
            out.dest = DEST_IR;
         end
         // PC <- PC + 1
         FETCH2, LDI2, LD4, ST4, BRA3, BRZ3, BRN3, BRC3, BRV3: begin
            out.srcA   = MUX_PC;
            out.alu_op = F_A_PLUS_1;
            out.dest   = DEST_PC;
         end
         ADD: begin
            out.alu_op = F_A_PLUS_B;
            out.dest   = DEST_REG;
            out.lcc_L  = LOAD_CC;
         end
         SUB: begin
            out.alu_op = F_A_MINUS_B;
            out.dest   = DEST_REG;
            out.lcc_L  = LOAD_CC;
         end
         AND: begin
            out.alu_op = F_A_AND_B;
            out.dest   = DEST_REG;
            out.lcc_L  = LOAD_CC;
         end
         OR: begin
            out.alu_op = F_A_OR_B;
            out.dest   = DEST_REG;
            out.lcc_L  = LOAD_CC;
         end
         XOR: begin
            out.alu_op = F_A_XOR_B;
            out.dest   = DEST_REG;
            out.lcc_L  = LOAD_CC;
         end
         NOT: begin
            out.alu_op = F_A_NOT;
            out.dest   = DEST_REG;
            out.lcc_L  = LOAD_CC;
         end
         // MOV does not touch the condition codes.
         MOV: begin
            out.alu_op = F_B;
            out.dest   = DEST_REG;
         end
         // Memory data goes to a register and sets the CCs.
         LDI1, LD3: begin
            out.re_L  = MEM_RD;
            out.dest  = DEST_REG;
            out.lcc_L = LOAD_CC;
         end
         // Memory data goes to MDR (an address or a branch target).
         LD1, ST1, BRA1, BRZ1, BRN1, BRC1, BRV1: begin
            out.re_L = MEM_RD;
            out.dest = DEST_MDR;
         end
         // MAR <- MDR
         LD2, ST2: begin
            out.srcA = MUX_MDR;
            out.dest = DEST_MAR;
         end
         ST3: begin
            out.srcB   = MUX_REG;
            out.alu_op = F_B;
            out.we_L   = MEM_WR;
         end
         // PC <- MDR (taken branch)
         BRA2, BRZ2, BRN2, BRC2, BRV2: begin
            out.srcA = MUX_MDR;
            out.dest = DEST_PC;
         end
`ifdef ADD32_EN
         // Both halves use the same controls. ADD32sel makes the datapath
         // pick the low word first and then the high word with the carry.
         ADD32, ADD321: begin
            out.alu_op = F_A_PLUS_B;
            out.dest   = DEST_REG;
            out.lcc_L  = LOAD_CC;
            ADD32sel   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign currState = state_q;
   assign nextState = state_d;

endmodule

// File: tb/tb_control_path.sv
// -----------------------------------------------------------------------------
// tb_control_path
// Directed bench for control_path. A table of per-cycle records holds the
// inputs and the expected state and outputs for a continuous instruction
// stream that starts right after reset. Hand-written sequences cover ADD32 or
// STOP (depending on ADD32_EN), nextState in DECODE, and an asynchronous
// reset during LD2.
// -----------------------------------------------------------------------------
module tb_control_path;
   import control_path_pkg::*;

   logic        clock;
   logic        reset_L;
   logic [15:0] IRIn;
   logic [3:0]  CCin;
   controlPts   out;
   logic        ADD32sel;
   opcode_t     currState;
   opcode_t     nextState;

   int n_checks = 0;
   int n_pass   = 0;

   control_path dut (
      .clock     (clock),
      .reset_L   (reset_L),
      .IRIn      (IRIn),
      .CCin      (CCin),
      .out       (out),
      .ADD32sel  (ADD32sel),
      .currState (currState),
      .nextState (nextState)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] ir;
      logic [3:0]  cc;
      opcode_t     st;
      controlPts   pts;
   } vec_t;

   vec_t vecs[$];

   function automatic controlPts cp(alu_op_t a, srcMux_t sa, srcMux_t sb,
                                    dest_t d, loadCC_t l, memRd_t r, memWr_t w);
      controlPts p;
      p.alu_op = a;
      p.srcA   = sa;
      p.srcB   = sb;
      p.dest   = d;
      p.lcc_L  = l;
      p.re_L   = r;
      p.we_L   = w;
      return p;
   endfunction

   task automatic add_vec(input logic [15:0] ir, input logic [3:0] cc,
                          input opcode_t st, input controlPts p);
      vec_t v;
      v.ir  = ir;
      v.cc  = cc;
      v.st  = st;
      v.pts = p;
      vecs.push_back(v);
   endtask

   task automatic add_fetch(input logic [15:0] ir, input logic [3:0] cc);
      add_vec(ir, cc, FETCH,  cp(F_A, MUX_PC, MUX_REG, DEST_MAR, NO_LOAD, NO_RD, NO_WR));
      add_vec(ir, cc, FETCH1, cp(F_A, MUX_REG, MUX_REG, DEST_IR, NO_LOAD, MEM_RD, NO_WR));
      add_vec(ir, cc, FETCH2, cp(F_A_PLUS_1, MUX_PC, MUX_REG, DEST_PC, NO_LOAD, NO_RD, NO_WR));
      add_vec(ir, cc, DECODE, cp(F_A, MUX_REG, MUX_REG, DEST_NONE, NO_LOAD, NO_RD, NO_WR));
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // ---------------- test ----------------
   opcode_t st_log[16];
   logic    sel_log[16];
   int      cnt;

   initial begin
      // Stream: ADD r1,r2 ; BRZ taken ; BRZ not taken ; ST ; MOV
      add_fetch(16'h000A, 4'b0000);
      add_vec(16'h000A, 4'b0000, ADD, cp(F_A_PLUS_B, MUX_REG, MUX_REG, DEST_REG, LOAD_CC, NO_RD, NO_WR));

      add_fetch(16'h2200, 4'b1000);
      add_vec(16'h2200, 4'b1000, BRZ,  cp(F_A, MUX_PC, MUX_REG, DEST_MAR, NO_LOAD, NO_RD, NO_WR));
      add_vec(16'h2200, 4'b1000, BRZ1, cp(F_A, MUX_REG, MUX_REG, DEST_MDR, NO_LOAD, MEM_RD, NO_WR));
      add_vec(16'h2200, 4'b1000, BRZ2, cp(F_A, MUX_MDR, MUX_REG, DEST_PC, NO_LOAD, NO_RD, NO_WR));

      add_fetch(16'h2200, 4'b0111);
      add_vec(16'h2200, 4'b0111, BRZ,  cp(F_A, MUX_PC, MUX_REG, DEST_MAR, NO_LOAD, NO_RD, NO_WR));
      add_vec(16'h2200, 4'b0111, BRZ1, cp(F_A, MUX_REG, MUX_REG, DEST_MDR, NO_LOAD, MEM_RD, NO_WR));
      add_vec(16'h2200, 4'b0111, BRZ3, cp(F_A_PLUS_1, MUX_PC, MUX_REG, DEST_PC, NO_LOAD, NO_RD, NO_WR));

      add_fetch(16'h1400, 4'b0000);
      add_vec(16'h1400, 4'b0000, ST,  cp(F_A, MUX_PC, MUX_REG, DEST_MAR, NO_LOAD, NO_RD, NO_WR));
      add_vec(16'h1400, 4'b0000, ST1, cp(F_A, MUX_REG, MUX_REG, DEST_MDR, NO_LOAD, MEM_RD, NO_WR));
      add_vec(16'h1400, 4'b0000, ST2, cp(F_A, MUX_MDR, MUX_REG, DEST_MAR, NO_LOAD, NO_RD, NO_WR));
      add_vec(16'h1400, 4'b0000, ST3, cp(F_B, MUX_REG, MUX_REG, DEST_NONE, NO_LOAD, NO_RD, MEM_WR));
      add_vec(16'h1400, 4'b0000, ST4, cp(F_A_PLUS_1, MUX_PC, MUX_REG, DEST_PC, NO_LOAD, NO_RD, NO_WR));

      add_fetch(16'h0C00, 4'b0000);
      add_vec(16'h0C00, 4'b0000, MOV, cp(F_B, MUX_REG, MUX_REG, DEST_REG, NO_LOAD, NO_RD, NO_WR));

      // ---- reset ----
      reset_L = 1'b0;
      IRIn    = 16'h0000;
      CCin    = 4'b0000;
      repeat (2) @(negedge clock);
      check("reset state", 32'(currState), 32'(FETCH));
      check("reset dest",  32'(out.dest),  32'(DEST_MAR));
      check("reset re_L",  32'(out.re_L),  32'(NO_RD));
      check("reset next",  32'(nextState), 32'(FETCH1));
      reset_L = 1'b1;

      // ---- table-driven stream ----
      for (int i = 0; i < vecs.size(); i++) begin
         IRIn = vecs[i].ir;
         CCin = vecs[i].cc;
         #1;
         check($sformatf("v%0d state", i), 32'(currState), 32'(vecs[i].st));
         check($sformatf("v%0d out", i),   32'(out),       32'(vecs[i].pts));
         check($sformatf("v%0d sel", i),   32'(ADD32sel),  32'd0);
         @(posedge clock);
         @(negedge clock);
      end

      // ---- opcode 7'h20: ADD32 or STOP ----
      check("after stream", 32'(currState), 32'(FETCH));
      IRIn = 16'h4000;
      CCin = 4'b0000;
      for (int c = 0; c < 16; c++) begin
         st_log[c]  = currState;
         sel_log[c] = ADD32sel;
         tick();
      end
      check("op20 decode", 32'(st_log[3]), 32'(DECODE));
`ifdef ADD32_EN
      check("add32 lo", 32'(st_log[4]), 32'(ADD32));
      check("add32 hi", 32'(st_log[5]), 32'(ADD321));
      check("add32 ret", 32'(st_log[6]), 32'(FETCH));
      cnt = 0;
      for (int c = 0; c < 9; c++) if (sel_log[c]) cnt++;
      check("add32 sel cycles", 32'(cnt), 32'd2);
`else
      cnt = 0;
      for (int c = 4; c < 16; c++) if (st_log[c] == STOP) cnt++;
      check("stop hold cycles", 32'(cnt), 32'd12);
      cnt = 0;
      for (int c = 0; c < 16; c++) if (sel_log[c]) cnt++;
      check("stop sel cycles", 32'(cnt), 32'd0);
      check("stop out", 32'(out),
            32'(cp(F_A, MUX_REG, MUX_REG, DEST_NONE, NO_LOAD, NO_RD, NO_WR)));
`endif

      // ---- LD with asynchronous reset in LD2 ----
      reset_L = 1'b0;
      tick();
      reset_L = 1'b1;
      IRIn = 16'h1200;
      for (int c = 0; c < 6; c++) begin
         if (c == 3) check("ld decode next", 32'(nextState), 32'(LD));
         tick();
      end
      check("ld2 state", 32'(currState), 32'(LD2));
      check("ld2 out", 32'(out),
            32'(cp(F_A, MUX_MDR, MUX_REG, DEST_MAR, NO_LOAD, NO_RD, NO_WR)));
      check("ld2 next", 32'(nextState), 32'(LD3));
      #2;
      reset_L = 1'b0;
      #1;
      check("async reset state", 32'(currState), 32'(FETCH));
      check("async reset dest",  32'(out.dest),  32'(DEST_MAR));
      @(negedge clock);
      check("reset hold state", 32'(currState), 32'(FETCH));
      reset_L = 1'b1;
      tick();
      check("post reset state", 32'(currState), 32'(FETCH1));
      check("post reset re_L",  32'(out.re_L),  32'(MEM_RD));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
